// File: rtl/ac_motor_pwm_monitor.sv
// ac_motor_pwm_monitor: per-carrier-period leg on-time, dead time and signed duty of an H-bridge drive.
// Dead-time violation tracking is built only when AC_MOTOR_MONITOR_DEADTIME_CHECK_EN is defined.
module ac_motor_pwm_monitor #(
    parameter int CNT_BITS = 16,
    parameter int MIN_DEAD = 2
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       ENABLE,
    input  logic                       SYNC,
    input  logic                       IN1,
    input  logic                       IN2,
    input  logic                       CLEAR,
    output logic signed [CNT_BITS:0]   DUTY,
    output logic [CNT_BITS-1:0]        PERIOD,
    output logic [CNT_BITS-1:0]        DEAD,
    output logic                       VALID,
    output logic                       SHOOT_FAULT,
    output logic                       DEAD_FAULT,
    output logic                       OVERFLOW
);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_e;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
    endfunction

    // [0],[1] form the synchroniser; [2] is the sample stage all measurement logic reads
    logic [2:0] sync_sh_q, in1_sh_q, in2_sh_q;
    logic       sync_prev_q;

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] period_acc_q, period_acc_d;
    logic [CNT_BITS-1:0] on1_acc_q, on1_acc_d;
    logic [CNT_BITS-1:0] on2_acc_q, on2_acc_d;
    logic [CNT_BITS-1:0] dead_acc_q, dead_acc_d;
    logic [CNT_BITS:0]   duty_q, duty_d;
    logic [CNT_BITS-1:0] period_q, period_d;
    logic [CNT_BITS-1:0] dead_q, dead_d;
    logic                valid_q, valid_d;
    logic                shoot_q, shoot_d;
    logic                ovf_q, ovf_d;

    logic in1_s, in2_s, sync_edge, leg1, leg2, both_off, both_on;

    assign in1_s     = in1_sh_q[2];
    assign in2_s     = in2_sh_q[2];
    assign sync_edge = sync_sh_q[2] & ~sync_prev_q;
    assign leg1      = in1_s & ~in2_s;
    assign leg2      = in2_s & ~in1_s;
    assign both_off  = ~in1_s & ~in2_s;
    assign both_on   = in1_s & in2_s;

    always_comb begin
        state_d      = state_q;
        period_acc_d = period_acc_q;
        on1_acc_d    = on1_acc_q;
        on2_acc_d    = on2_acc_q;
        dead_acc_d   = dead_acc_q;
        duty_d       = duty_q;
        period_d     = period_q;
        dead_d       = dead_q;
        valid_d      = 1'b0;
        shoot_d      = CLEAR ? 1'b0 : shoot_q;
        ovf_d        = CLEAR ? 1'b0 : ovf_q;

        case (state_q)
            IDLE: begin
                period_acc_d = '0;
                on1_acc_d    = '0;
                on2_acc_d    = '0;
                dead_acc_d   = '0;
                if (ENABLE) state_d = ARMED;
            end
            ARMED, MEASURE: begin
                if (!ENABLE) begin
                    state_d      = IDLE;
                    period_acc_d = '0;
                    on1_acc_d    = '0;
                    on2_acc_d    = '0;
                    dead_acc_d   = '0;
                end else begin
                    if (both_on) shoot_d = 1'b1;
                    if (sync_edge) begin
                        if (state_q == MEASURE) begin
                            duty_d   = {1'b0, on1_acc_q} - {1'b0, on2_acc_q};
                            period_d = period_acc_q;
                            dead_d   = dead_acc_q;
                            valid_d  = 1'b1;
                        end
                        // the edge cycle is the first sample of the new period
                        state_d      = MEASURE;
                        period_acc_d = CNT_ONE;
                        on1_acc_d    = CNT_BITS'(leg1);
                        on2_acc_d    = CNT_BITS'(leg2);
                        dead_acc_d   = CNT_BITS'(both_off);
                    end else if (state_q == MEASURE) begin
                        if (period_acc_q == CNT_MAX) ovf_d = 1'b1;
                        period_acc_d = sat_inc(period_acc_q, 1'b1);
                        on1_acc_d    = sat_inc(on1_acc_q, leg1);
                        on2_acc_d    = sat_inc(on2_acc_q, leg2);
                        dead_acc_d   = sat_inc(dead_acc_q, both_off);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_sh_q    <= '0;
            in1_sh_q     <= '0;
            in2_sh_q     <= '0;
            sync_prev_q  <= 1'b0;
            state_q      <= IDLE;
            period_acc_q <= '0;
            on1_acc_q    <= '0;
            on2_acc_q    <= '0;
            dead_acc_q   <= '0;
            duty_q       <= '0;
            period_q     <= '0;
            dead_q       <= '0;
            valid_q      <= 1'b0;
            shoot_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            sync_sh_q    <= {sync_sh_q[1:0], SYNC};
            in1_sh_q     <= {in1_sh_q[1:0], IN1};
            in2_sh_q     <= {in2_sh_q[1:0], IN2};
            sync_prev_q  <= sync_sh_q[2];
            state_q      <= state_d;
            period_acc_q <= period_acc_d;
            on1_acc_q    <= on1_acc_d;
            on2_acc_q    <= on2_acc_d;
            dead_acc_q   <= dead_acc_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            dead_q       <= dead_d;
            valid_q      <= valid_d;
            shoot_q      <= shoot_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef AC_MOTOR_MONITOR_DEADTIME_CHECK_EN
    localparam logic [1:0] LEG_NONE = 2'd0;
    localparam logic [1:0] LEG_ONE  = 2'd1;
    localparam logic [1:0] LEG_TWO  = 2'd2;

    logic [1:0]          last_leg_q, last_leg_d;
    logic [CNT_BITS-1:0] run_q, run_d;
    logic                dead_fault_q, dead_fault_d;
    logic                run_short;

    assign run_short = (run_q < CNT_BITS'(MIN_DEAD));

    always_comb begin
        last_leg_d   = last_leg_q;
        run_d        = run_q;
        dead_fault_d = CLEAR ? 1'b0 : dead_fault_q;
        if (state_q == IDLE) begin
            last_leg_d = LEG_NONE;
            run_d      = '0;
        end else if (both_off) begin
            run_d = sat_inc(run_q, 1'b1);
        end else if (leg1) begin
            if ((last_leg_q == LEG_TWO) && run_short) dead_fault_d = 1'b1;
            last_leg_d = LEG_ONE;
            run_d      = '0;
        end else if (leg2) begin
            if ((last_leg_q == LEG_ONE) && run_short) dead_fault_d = 1'b1;
            last_leg_d = LEG_TWO;
            run_d      = '0;
        end else begin
            // shoot-through breaks the off-run without naming a new active leg
            run_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_leg_q   <= LEG_NONE;
            run_q        <= '0;
            dead_fault_q <= 1'b0;
        end else begin
            last_leg_q   <= last_leg_d;
            run_q        <= run_d;
            dead_fault_q <= dead_fault_d;
        end
    end

    assign DEAD_FAULT = dead_fault_q;
`else
    assign DEAD_FAULT = 1'b0;
`endif

    assign DUTY        = $signed(duty_q);
    assign PERIOD      = period_q;
    assign DEAD        = dead_q;
    assign VALID       = valid_q;
    assign SHOOT_FAULT = shoot_q;
    assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_ac_motor_pwm_monitor.sv
// Scoreboard bench for ac_motor_pwm_monitor: a 16-bit instance for duty/fault behaviour and a
// 4-bit instance for period saturation.
module tb_ac_motor_pwm_monitor;
    localparam int CB = 16;

    logic CLK = 1'b0;
    logic RESET_N, ENABLE, SYNC, IN1, IN2, CLEAR;
    logic signed [CB:0] DUTY;
    logic [CB-1:0] PERIOD, DEAD;
    logic VALID, SHOOT_FAULT, DEAD_FAULT, OVERFLOW;

    logic en4, sync4, clr4;
    logic signed [4:0] duty4;
    logic [3:0] period4, dead4;
    logic valid4, shoot4, deadf4, ovf4;

    always #5 CLK = ~CLK;

    ac_motor_pwm_monitor #(.CNT_BITS(CB), .MIN_DEAD(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .SYNC(SYNC), .IN1(IN1), .IN2(IN2),
        .CLEAR(CLEAR), .DUTY(DUTY), .PERIOD(PERIOD), .DEAD(DEAD), .VALID(VALID),
        .SHOOT_FAULT(SHOOT_FAULT), .DEAD_FAULT(DEAD_FAULT), .OVERFLOW(OVERFLOW)
    );

    ac_motor_pwm_monitor #(.CNT_BITS(4), .MIN_DEAD(2)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(en4), .SYNC(sync4), .IN1(1'b0), .IN2(1'b0),
        .CLEAR(clr4), .DUTY(duty4), .PERIOD(period4), .DEAD(dead4), .VALID(valid4),
        .SHOOT_FAULT(shoot4), .DEAD_FAULT(deadf4), .OVERFLOW(ovf4)
    );

    typedef struct packed {
        logic [CB:0]   duty;
        logic [CB-1:0] period;
        logic [CB-1:0] dead;
    } exp_t;

    typedef struct packed {
        logic [4:0] duty;
        logic [3:0] period;
        logic [3:0] dead;
    } exp4_t;

    exp_t  q[$];
    exp4_t q4[$];
    exp_t  mon_e;
    exp4_t mon4_e;
    int vectors = 0;
    int miscompares = 0;
    logic exp_df;

    task automatic check(input string name, input logic [CB:0] act, input logic [CB:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One carrier period: SYNC high for sync_len clocks, IN1 n1, off o1, IN2 n2, off o2
    task automatic period_run(input int n1, input int o1, input int n2, input int o2,
                              input bit expect_it, input int sync_len);
        exp_t e;
        int len;
        len = n1 + o1 + n2 + o2;
        if (expect_it) begin
            e.duty   = (CB+1)'(n1 - n2);
            e.period = CB'(len);
            e.dead   = CB'(o1 + o2);
            q.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            SYNC = (i < sync_len);
            IN1  = (i < n1);
            IN2  = (i >= n1 + o1) && (i < n1 + o1 + n2);
            tick(1);
        end
        SYNC = 1'b0;
        IN1  = 1'b0;
        IN2  = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && VALID === 1'b1) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid: DUTY=0x%0h PERIOD=%0d DEAD=%0d, expected no VALID",
                         DUTY, PERIOD, DEAD);
            end else begin
                mon_e = q.pop_front();
                if (DUTY !== mon_e.duty || PERIOD !== mon_e.period || DEAD !== mon_e.dead) begin
                    miscompares++;
                    $display("FAIL period_report: got DUTY=0x%0h PERIOD=%0d DEAD=%0d, expected DUTY=0x%0h PERIOD=%0d DEAD=%0d",
                             DUTY, PERIOD, DEAD, mon_e.duty, mon_e.period, mon_e.dead);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && valid4 === 1'b1) begin
            vectors++;
            if (q4.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid4: DUTY=0x%0h PERIOD=%0d DEAD=%0d, expected no VALID",
                         duty4, period4, dead4);
            end else begin
                mon4_e = q4.pop_front();
                if (duty4 !== mon4_e.duty || period4 !== mon4_e.period || dead4 !== mon4_e.dead) begin
                    miscompares++;
                    $display("FAIL sat_report: got DUTY=0x%0h PERIOD=%0d DEAD=%0d, expected DUTY=0x%0h PERIOD=%0d DEAD=%0d",
                             duty4, period4, dead4, mon4_e.duty, mon4_e.period, mon4_e.dead);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef AC_MOTOR_MONITOR_DEADTIME_CHECK_EN
        exp_df = 1'b1;
`else
        exp_df = 1'b0;
`endif
        RESET_N = 1'b0; ENABLE = 1'b0; SYNC = 1'b0; IN1 = 1'b0; IN2 = 1'b0; CLEAR = 1'b0;
        en4 = 1'b0; sync4 = 1'b0; clr4 = 1'b0;
        #23;
        check("rst_duty",   DUTY, '0);
        check("rst_period", (CB+1)'(PERIOD), '0);
        check("rst_dead",   (CB+1)'(DEAD), '0);
        check("rst_valid",  (CB+1)'(VALID), '0);
        check("rst_shoot",  (CB+1)'(SHOOT_FAULT), '0);
        check("rst_deadf",  (CB+1)'(DEAD_FAULT), '0);
        check("rst_ovf",    (CB+1)'(OVERFLOW), '0);
        check("rst_ovf4",   (CB+1)'(ovf4), '0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        tick(2);

        ENABLE = 1'b1;
        tick(2);
        period_run(60, 2, 36, 2, 1'b1, 1);
        period_run(60, 2, 36, 2, 1'b1, 1);
        period_run(10, 2, 86, 2, 1'b1, 1);
        period_run(10, 2, 86, 2, 1'b0, 1);
        check("normal_shoot", (CB+1)'(SHOOT_FAULT), '0);
        check("normal_deadf", (CB+1)'(DEAD_FAULT), '0);

        // one-clock overlap: flag must appear exactly on the third edge after capture
        IN1 = 1'b1; IN2 = 1'b1;
        @(posedge CLK); #1;
        IN1 = 1'b0; IN2 = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("shoot_early", (CB+1)'(SHOOT_FAULT), '0);
        @(posedge CLK);
        @(negedge CLK);
        check("shoot_set", (CB+1)'(SHOOT_FAULT), (CB+1)'(1));
        @(posedge CLK); #1;
        tick(3);
        CLEAR = 1'b1; tick(1); CLEAR = 1'b0;
        check("shoot_clear", (CB+1)'(SHOOT_FAULT), '0);

        IN1 = 1'b1; IN2 = 1'b1;
        tick(1);
        IN1 = 1'b0; IN2 = 1'b0;
        tick(2);
        CLEAR = 1'b1; tick(1); CLEAR = 1'b0;
        check("shoot_clear_coincident", (CB+1)'(SHOOT_FAULT), (CB+1)'(1));
        tick(3);
        CLEAR = 1'b1; tick(1); CLEAR = 1'b0;
        check("shoot_clear_again", (CB+1)'(SHOOT_FAULT), '0);

        IN1 = 1'b1; tick(4); IN1 = 1'b0; tick(1); IN2 = 1'b1; tick(4); IN2 = 1'b0;
        tick(6);
        check("deadf_opposite_short", (CB+1)'(DEAD_FAULT), (CB+1)'(exp_df));
        CLEAR = 1'b1; tick(1); CLEAR = 1'b0;
        check("deadf_clear", (CB+1)'(DEAD_FAULT), '0);
        IN1 = 1'b1; tick(4); IN1 = 1'b0; tick(1); IN1 = 1'b1; tick(4); IN1 = 1'b0;
        tick(6);
        check("deadf_same_leg", (CB+1)'(DEAD_FAULT), '0);

        // disable mid-period: pending period discarded, outputs hold, SYNC ignored
        ENABLE = 1'b0;
        tick(5);
        check("hold_duty",   DUTY, (CB+1)'(-76));
        check("hold_period", (CB+1)'(PERIOD), (CB+1)'(100));
        check("hold_dead",   (CB+1)'(DEAD), (CB+1)'(4));
        SYNC = 1'b1; tick(1); SYNC = 1'b0;
        tick(10);
        ENABLE = 1'b1;
        tick(1);
        check("hold_duty_reenable", DUTY, (CB+1)'(-76));
        period_run(30, 5, 60, 5, 1'b1, 3);
        period_run(60, 2, 36, 2, 1'b0, 1);
        for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
        check("drain_main", (CB+1)'(q.size()), '0);
        check("main_no_ovf", (CB+1)'(OVERFLOW), '0);

        // 4-bit instance: 40-clock periods saturate every counter
        en4 = 1'b1;
        tick(2);
        for (int k = 0; k < 3; k++) begin
            if (k < 2) q4.push_back('{duty: 5'd0, period: 4'd15, dead: 4'd15});
            sync4 = 1'b1; tick(1); sync4 = 1'b0;
            tick(39);
        end
        for (int i = 0; i < 20 && q4.size() > 0; i++) tick(1);
        check("drain_sat", (CB+1)'(q4.size()), '0);
        check("ovf_set", (CB+1)'(ovf4), (CB+1)'(1));
        en4 = 1'b0;
        tick(5);
        check("ovf_sticky", (CB+1)'(ovf4), (CB+1)'(1));
        clr4 = 1'b1; tick(1); clr4 = 1'b0;
        check("ovf_clear", (CB+1)'(ovf4), '0);

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ac_motor_pwm_monitor.md
# ac_motor_pwm_monitor

Feedback monitor at the load end of the AC motor PWM path: samples the two H-bridge leg drive signals, measures per-carrier-period on-time of each leg and dead time, and reports a signed duty value once per period. It also flags shoot-through (both legs on), dead-time violations and over-long periods. It sits between the bridge drive pins and the motor control logic, closing the loop on what the comparator actually drove.

## Interface
- CNT_BITS, 16: width of the period/on-time/dead-time counters.
- MIN_DEAD, 2: minimum both-legs-off run, in clocks, required between opposite-leg activations.

- CLK  in  1  system clock; all logic on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  measurement enable; low forces IDLE.
- SYNC  in  1  carrier period marker (high at triangle peak); asynchronous, synchronised internally.
- IN1  in  1  leg 1 drive sample; asynchronous.
- IN2  in  1  leg 2 drive sample; asynchronous.
- CLEAR  in  1  synchronous clear of sticky flags.
- DUTY  out  CNT_BITS+1  signed on1 − on2 for the last complete period.
- PERIOD  out  CNT_BITS  clocks in the last complete period.
- DEAD  out  CNT_BITS  clocks with both legs off in the last complete period.
- VALID  out  1  one-cycle strobe: DUTY/PERIOD/DEAD just updated.
- SHOOT_FAULT  out  1  sticky: IN1 and IN2 sampled high together.
- DEAD_FAULT  out  1  sticky: opposite-leg switch with off-run < MIN_DEAD.
- OVERFLOW  out  1  sticky: period counter saturated.

## Operation
- SYNC, IN1, IN2 each pass a 2-flop synchroniser; all logic uses synchronised values (s1, s2). SYNC edge = s2 high and previous s2 low.
- States: IDLE, ARMED, MEASURE.
  - IDLE: entered on reset or ENABLE low. Accumulators cleared. Outputs DUTY/PERIOD/DEAD hold, VALID 0, sticky flags hold. ENABLE high → ARMED.
  - ARMED: waits for first SYNC edge (discards partial period). On edge: clear accumulators, count that cycle as first sample, → MEASURE.
  - MEASURE: per cycle, period += 1; on1 += IN1&~IN2; on2 += IN2&~IN1; dead += ~IN1&~IN2; both-high cycles count in period only. On SYNC edge: transfer on1−on2, period, dead to outputs, pulse VALID, restart accumulators with the edge cycle as sample 1.
- Counters saturate at 2^CNT_BITS−1; no wrap. Period saturation sets OVERFLOW; that period still reports on next SYNC edge with saturated values.
- DUTY: on1 and on2 zero-extended to CNT_BITS+1, subtracted, two's-complement result.
- SHOOT_FAULT set any cycle IN1&IN2 in ARMED or MEASURE.
- Dead-time check (see Configuration): track last active leg and current both-off run length. When a leg goes active, last active leg was the other leg, and run < MIN_DEAD → set DEAD_FAULT. Re-activation of same leg never faults. Run counter saturates; tracking resets on IDLE.
- CLEAR clears all three sticky flags; a fault condition in the same cycle as CLEAR leaves the flag set.

## Timing
- Reset values: DUTY 0, PERIOD 0, DEAD 0, VALID 0, SHOOT_FAULT 0, DEAD_FAULT 0, OVERFLOW 0; state IDLE; synchronisers 0.
- Input latency: pin change visible to accumulators/fault logic 2 clocks after first sampling edge; fault flag visible 1 clock later (3 total).
- SYNC pin high sampled at edge k → outputs and VALID registered at edge k+3; VALID high exactly one cycle.
- SYNC held high multiple cycles = one edge. SYNC edges 1 clock apart are legal: PERIOD = 1.
- ENABLE low mid-MEASURE: next cycle IDLE, pending period discarded, no VALID.
- RESET_N assertion mid-operation: all state and outputs to reset values immediately, independent of CLK.

## Configuration
- AC_MOTOR_MONITOR_DEADTIME_CHECK_EN defined: last-leg tracking and run-length logic built; DEAD_FAULT behaves as above.
- Undefined: tracking logic omitted, DEAD_FAULT tied 0; DEAD output and all other behaviour unchanged.

## Test plan
- Reset, ENABLE=1, SYNC every 100 clocks, IN1 high 60, both off 2, IN2 high 36, both off 2 → first VALID after second SYNC edge; DUTY=+24, PERIOD=100, DEAD=4, no flags.
- Same period with IN1 10 / IN2 86 / off 4 → DUTY=−76 (CNT_BITS+1 two's complement), DEAD=4.
- IN1 and IN2 high together 1 clock → SHOOT_FAULT=1 three clocks later; CLEAR pulse → 0; CLEAR coincident with new overlap → stays 1.
- MIN_DEAD=2, IN1 off then IN2 on after 1 off clock → DEAD_FAULT=1 (macro defined) / 0 (undefined); IN1 off 1 clock then IN1 on → no fault.
- CNT_BITS=4, SYNC gap 40 clocks → PERIOD=15, OVERFLOW=1 sticky.
- ENABLE dropped mid-period, re-raised → no VALID until second SYNC edge after re-enable; outputs hold prior values meanwhile.
